// File: rtl/vga_scan_controller.sv
// vga_scan_controller: raster scan generator with a pipe-matched sync/blank delay line and RGB332 to VGA DAC expansion.
// Optional colour-bar generator is built when VGA_TEST_PATTERN_EN is defined (adds input testPattern).
module vga_scan_controller #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int PIPE_DELAY = 2
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        pixelEnable,
  input  logic [7:0]  pixelRGB,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        testPattern,
`endif
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        visible,
  output logic        startOfFrame,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N
);
  localparam logic [10:0] H_LAST = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [10:0] V_LAST = 11'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [10:0] H_ACT  = 11'(H_VISIBLE);
  localparam logic [10:0] V_ACT  = 11'(V_VISIBLE);
  localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  logic [10:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic        visible_q, visible_d, sof_q, sof_d;
  logic [2:0]  dly_q [PIPE_DELAY];
  logic [2:0]  dly_d [PIPE_DELAY];
  logic        hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
  logic [23:0] rgb_q, rgb_d;
  logic [2:0]  tap;
  logic [7:0]  col;
  // next scan position; flags are derived from it so they line up with the counters
  always_comb begin
    hcnt_d    = (hcnt_q == H_LAST) ? '0 : hcnt_q + 11'd1;
    vcnt_d    = (hcnt_q != H_LAST) ? vcnt_q : (vcnt_q == V_LAST) ? '0 : vcnt_q + 11'd1;
    visible_d = (hcnt_d < H_ACT) && (vcnt_d < V_ACT);
    sof_d     = (hcnt_d == '0) && (vcnt_d == '0);
  end
  // scan counters start one step before (0,0) so the first enabled edge opens a frame
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      hcnt_q    <= H_LAST;
      vcnt_q    <= V_LAST;
      visible_q <= 1'b0;
      sof_q     <= 1'b0;
    end else if (pixelEnable) begin
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      visible_q <= visible_d;
      sof_q     <= sof_d;
    end
  // raw {hs, vs, blank} enter a shift register matching the drawer/mixer latency
  always_comb begin
    dly_d[0] = {~(hcnt_q >= HS_BEG && hcnt_q <= HS_END), ~(vcnt_q >= VS_BEG && vcnt_q <= VS_END), visible_q};
    for (int i = 1; i < PIPE_DELAY; i++) dly_d[i] = dly_q[i-1];
  end
  // delay line clears to idle sync and blanked video
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      for (int i = 0; i < PIPE_DELAY; i++) dly_q[i] <= 3'b110;
    end else if (pixelEnable) begin
      dly_q <= dly_d;
    end
`ifdef VGA_TEST_PATTERN_EN
  localparam logic [10:0] BAR_W = 11'(H_VISIBLE / 8);
  localparam logic [7:0]  BARS [8] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};
  logic [10:0] hdly_q [PIPE_DELAY];
  logic [10:0] hdly_d [PIPE_DELAY];
  logic [10:0] bar_idx;
  // horizontal count delayed alongside sync picks the bar for the pixel leaving the pipe
  always_comb begin
    hdly_d[0] = hcnt_q;
    for (int i = 1; i < PIPE_DELAY; i++) hdly_d[i] = hdly_q[i-1];
    bar_idx = hdly_q[PIPE_DELAY-1] / BAR_W;
    col     = !testPattern ? pixelRGB : (bar_idx < 11'd8) ? BARS[bar_idx[2:0]] : 8'h00;
  end
  // delayed horizontal count for the bar generator
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      for (int i = 0; i < PIPE_DELAY; i++) hdly_q[i] <= '0;
    end else if (pixelEnable) begin
      hdly_q <= hdly_d;
    end
`else
  // mixer colour is the only source
  always_comb col = pixelRGB;
`endif
  // expand RGB332 by bit replication and force black outside the active area
  always_comb begin
    tap     = dly_q[PIPE_DELAY-1];
    hs_d    = tap[2];
    vs_d    = tap[1];
    blank_d = tap[0];
    rgb_d   = tap[0] ? {col[7:5], col[7:5], col[7:6], col[4:2], col[4:2], col[4:3], {4{col[1:0]}}} : '0;
  end
  // output register re-aligns sync/blank with the returned colour
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      rgb_q   <= '0;
    end else if (pixelEnable) begin
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      rgb_q   <= rgb_d;
    end
  assign pixelX       = hcnt_q;
  assign pixelY       = vcnt_q;
  assign visible      = visible_q;
  assign startOfFrame = sof_q;
  assign VGA_HS       = hs_q;
  assign VGA_VS       = vs_q;
  assign VGA_BLANK_N  = blank_q;
  assign VGA_R        = rgb_q[23:16];
  assign VGA_G        = rgb_q[15:8];
  assign VGA_B        = rgb_q[7:0];
endmodule

// File: tb/tb_vga_scan_controller.sv
// tb_vga_scan_controller: randomized scan/colour stimulus checked every cycle against a linear-time raster model.
module tb_vga_scan_controller;
  localparam int HV = 16, HF = 2, HSY = 3, HB = 3;
  localparam int VV = 8, VF = 2, VSY = 2, VB = 2;
  localparam int PD = 3;
  localparam int HT = HV + HF + HSY + HB;
  localparam int VT = VV + VF + VSY + VB;
  localparam int TOT = HT * VT;
  logic        clk, resetN, pixelEnable, testPattern, chk;
  logic [7:0]  pixelRGB;
  logic [10:0] pixelX, pixelY;
  logic        visible, startOfFrame, VGA_HS, VGA_VS, VGA_BLANK_N;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic [7:0]  rgb_h [64];
  logic        tp_h [64];
  logic [7:0]  bars [8] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};
  int          n, checks, fails;

  vga_scan_controller #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB), .PIPE_DELAY(PD)
  ) dut (
`ifdef VGA_TEST_PATTERN_EN
    .testPattern(testPattern),
`endif
    .clk(clk), .resetN(resetN), .pixelEnable(pixelEnable), .pixelRGB(pixelRGB),
    .pixelX(pixelX), .pixelY(pixelY), .visible(visible), .startOfFrame(startOfFrame),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at n=%0d t=%0t", name, act, exp, n, $time);
    end
  endtask

  function automatic logic [23:0] expand(input logic [7:0] c);
    return {c[7:5], c[7:5], c[7:6], c[4:2], c[4:2], c[4:3], c[1:0], c[1:0], c[1:0], c[1:0]};
  endfunction

  always @(posedge clk or negedge resetN)
    if (!resetN) n = 0;
    else if (pixelEnable) begin
      n++;
      rgb_h[n % 64] = pixelRGB;
      tp_h[n % 64]  = testPattern;
    end

  always @(negedge clk) if (chk) begin : cmp
    int tc, to, xo, yo;
    logic bl, ehs, evs;
    logic [7:0] src;
    logic [23:0] ergb;
    tc = (n + TOT - 1) % TOT;
    check("pixelX", 32'(pixelX), 32'(tc % HT));
    check("pixelY", 32'(pixelY), 32'(tc / HT));
    check("visible", 32'(visible), 32'(n > 0 && tc % HT < HV && tc / HT < VV));
    check("startOfFrame", 32'(startOfFrame), 32'(n > 0 && tc == 0));
    if (n <= PD) begin
      ehs = 1'b1; evs = 1'b1; bl = 1'b0; ergb = '0;
    end else begin
      to  = (n + 2 * TOT - PD - 2) % TOT;
      xo  = to % HT;
      yo  = to / HT;
      ehs = !(xo >= HV + HF && xo < HV + HF + HSY);
      evs = !(yo >= VV + VF && yo < VV + VF + VSY);
      bl  = xo < HV && yo < VV;
      src = rgb_h[n % 64];
`ifdef VGA_TEST_PATTERN_EN
      if (bl && tp_h[n % 64]) src = bars[xo / (HV / 8)];
`endif
      ergb = bl ? expand(src) : '0;
    end
    check("VGA_HS", 32'(VGA_HS), 32'(ehs));
    check("VGA_VS", 32'(VGA_VS), 32'(evs));
    check("VGA_BLANK_N", 32'(VGA_BLANK_N), 32'(bl));
    check("VGA_RGB", 32'({VGA_R, VGA_G, VGA_B}), 32'(ergb));
  end

  task automatic step(input logic en, input logic [7:0] rgb, input logic tp);
    pixelEnable = en;
    pixelRGB    = rgb;
    testPattern = tp;
`ifndef VGA_TEST_PATTERN_EN
    testPattern = 1'b0;
`endif
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int k;
    checks = 0; fails = 0; n = 0; chk = 1'b0;
    resetN = 1'b1; pixelEnable = 1'b0; pixelRGB = '0; testPattern = 1'b0;
    #1 resetN = 1'b0;
    @(negedge clk) chk = 1'b1;
    @(negedge clk);
    check("rst_pixelX", 32'(pixelX), 32'd23);
    check("rst_pixelY", 32'(pixelY), 32'd13);
    check("rst_hs_vs_blank", 32'({VGA_HS, VGA_VS, VGA_BLANK_N}), 32'b110);
    resetN = 1'b1;
    step(1'b1, 8'h92, 1'b0);
    check("first_xy", 32'({pixelX, pixelY}), 32'd0);
    check("first_vis_sof", 32'({visible, startOfFrame}), 32'b11);
    repeat (4) step(1'b1, 8'h92, 1'b0);
    check("rgb_92", 32'({VGA_R, VGA_G, VGA_B}), 32'h9292AA);
    check("blank_n_on", 32'(VGA_BLANK_N), 32'd1);
    step(1'b1, 8'hE0, 1'b0);
    check("rgb_E0", 32'({VGA_R, VGA_G, VGA_B}), 32'hFF0000);
    repeat (15) step(1'b1, 8'hFF, 1'b0);
    check("rgb_blanked", 32'({VGA_R, VGA_G, VGA_B, VGA_BLANK_N}), 32'd0);
    repeat (1200) step(1'($urandom % 4 != 0), 8'($urandom), 1'($urandom));
    for (int i = 0; i < 80; i++) step(1'(i % 2 == 0), 8'($urandom), 1'($urandom));
    k = 0;
    while (VGA_HS !== 1'b0 && k < 400) begin
      step(1'b1, 8'($urandom), 1'b0);
      k++;
    end
    check("hs_low_seen", 32'(k < 400), 32'd1);
    #2 resetN = 1'b0;
    #1;
    check("mid_rst_hs_blank", 32'({VGA_HS, VGA_VS, VGA_BLANK_N}), 32'b110);
    check("mid_rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
    check("mid_rst_xy", 32'({pixelX, pixelY}), 32'({11'd23, 11'd13}));
    @(negedge clk) resetN = 1'b1;
    step(1'b1, 8'($urandom), 1'b1);
    check("restart_sof", 32'({pixelX, pixelY, startOfFrame}), 32'd1);
    repeat (750) step(1'b1, 8'($urandom), 1'($urandom));
    repeat (300) step(1'($urandom % 2), 8'($urandom), 1'b1);
    chk = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
